// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requester/UART environment.
interface uart_tx_arbiter_if #(
    parameter int PAYLOAD_W = 64
);
    logic                 req0_valid;
    logic [7:0]           req0_length;
    logic [7:0]           req0_type;
    logic [PAYLOAD_W-1:0] req0_data;
    logic                 req0_ready;

    logic                 req1_valid;
    logic [7:0]           req1_length;
    logic [7:0]           req1_type;
    logic [PAYLOAD_W-1:0] req1_data;
    logic                 req1_ready;

    logic                 transmit;
    logic [7:0]           tx_byte;
    logic                 is_transmitting;
    logic                 busy;
    logic                 grant;

    modport slave (
        input  req0_valid, req0_length, req0_type, req0_data,
        input  req1_valid, req1_length, req1_type, req1_data,
        input  is_transmitting,
        output req0_ready, req1_ready,
        output transmit, tx_byte, busy, grant
    );

    modport master (
        output req0_valid, req0_length, req0_type, req0_data,
        output req1_valid, req1_length, req1_type, req1_data,
        output is_transmitting,
        input  req0_ready, req1_ready,
        input  transmit, tx_byte, busy, grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin packet arbiter feeding a byte-wide UART transmitter.
// Each accepted packet is serialised as: length, 00, 00, type, payload bytes MSB first.
module uart_tx_arbiter #(
    parameter int PAYLOAD_W = 64
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int        PB      = PAYLOAD_W / 8;
    localparam logic [7:0] MAX_LEN = 8'(4 + PB);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]                req_valid;
    logic [1:0][7:0]           req_length;
    logic [1:0][7:0]           req_type;
    logic [1:0][PAYLOAD_W-1:0] req_data;
    logic [1:0][7:0]           norm_len;

    logic [1:0]           ready_reg, ready_next;
    logic                 grant_reg, grant_next;
    logic [7:0]           len_reg, len_next;
    logic [7:0]           type_reg, type_next;
    logic [PAYLOAD_W-1:0] shift_reg, shift_next;
    logic [7:0]           idx_reg, idx_next;
    logic                 transmit_reg, transmit_next;
    logic [7:0]           tx_byte_reg, tx_byte_next;

    logic       accept;
    logic       winner;
    logic       tx_fire;
    logic [7:0] cur_byte;

    assign req_valid  = {bus.req1_valid,  bus.req0_valid};
    assign req_length = {bus.req1_length, bus.req0_length};
    assign req_type   = {bus.req1_type,   bus.req0_type};
    assign req_data   = {bus.req1_data,   bus.req0_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_norm
            assign norm_len[gi] = (req_length[gi] == 8'd0)    ? 8'd0    :
                                  (req_length[gi] <  8'd4)    ? 8'd4    :
                                  (req_length[gi] >  MAX_LEN) ? MAX_LEN :
                                                                req_length[gi];
        end
    endgenerate

    // While a ready pulse is out the requester may still hold valid; blocking
    // accept for that cycle stops a dropped (L=0) packet being taken twice.
    assign accept  = (state_reg == IDLE) && (ready_reg == 2'b00) && (req_valid != 2'b00);
    assign winner  = (req_valid == 2'b11) ? ~grant_reg : req_valid[1];
    assign tx_fire = (state_reg == SEND) && !bus.is_transmitting;

    always_comb begin
        cur_byte = shift_reg[PAYLOAD_W-1 -: 8];
        case (idx_reg)
            8'd1:       cur_byte = len_reg;
            8'd2, 8'd3: cur_byte = 8'h00;
            8'd4:       cur_byte = type_reg;
            default:    cur_byte = shift_reg[PAYLOAD_W-1 -: 8];
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (norm_len[winner] != 8'd0)) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!bus.is_transmitting) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.is_transmitting) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.is_transmitting) begin
                    state_next = (idx_reg == len_reg) ? IDLE : SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_next    = 2'b00;
        grant_next    = grant_reg;
        len_next      = len_reg;
        type_next     = type_reg;
        shift_next    = shift_reg;
        idx_next      = idx_reg;
        transmit_next = tx_fire;
        tx_byte_next  = tx_byte_reg;

        if (accept) begin
            ready_next = winner ? 2'b10 : 2'b01;
            grant_next = winner;
            len_next   = norm_len[winner];
            type_next  = req_type[winner];
            shift_next = req_data[winner];
            idx_next   = 8'd1;
        end

        if (tx_fire) begin
            tx_byte_next = cur_byte;
            if (idx_reg >= 8'd5) begin
                shift_next = shift_reg << 8;
            end
        end

        if ((state_reg == WAIT_DONE) && !bus.is_transmitting && (idx_reg != len_reg)) begin
            idx_next = idx_reg + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg    <= 2'b00;
            grant_reg    <= 1'b1;
            len_reg      <= 8'd0;
            type_reg     <= 8'd0;
            shift_reg    <= '0;
            idx_reg      <= 8'd0;
            transmit_reg <= 1'b0;
            tx_byte_reg  <= 8'd0;
        end else begin
            ready_reg    <= ready_next;
            grant_reg    <= grant_next;
            len_reg      <= len_next;
            type_reg     <= type_next;
            shift_reg    <= shift_next;
            idx_reg      <= idx_next;
            transmit_reg <= transmit_next;
            tx_byte_reg  <= tx_byte_next;
        end
    end

    assign bus.req0_ready = ready_reg[0];
    assign bus.req1_ready = ready_reg[1];
    assign bus.transmit   = transmit_reg;
    assign bus.tx_byte    = tx_byte_reg;
    assign bus.grant      = grant_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a packet vector table plus hand-written
// sequences for latency, contention and mid-packet reset, against a UART busy model.
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.PAYLOAD_W(64)) bus ();

    uart_tx_arbiter #(.PAYLOAD_W(64)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // UART model: busy window opens rise_dly cycles after a transmit pulse, lasts busy_len cycles
    int rise_dly = 1;
    int busy_len = 10;
    int t_cnt = 0;
    logic [7:0] cap_q[$];
    int tx_while_busy = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;

    assign bus.is_transmitting = (t_cnt >= rise_dly) && (t_cnt < rise_dly + busy_len);

    always @(posedge clk) begin
        if (!rst_n) begin
            t_cnt <= 0;
        end else begin
            if (bus.req0_ready) rdy0_cnt <= rdy0_cnt + 1;
            if (bus.req1_ready) rdy1_cnt <= rdy1_cnt + 1;
            if (bus.transmit) begin
                cap_q.push_back(bus.tx_byte);
                if (bus.is_transmitting) tx_while_busy <= tx_while_busy + 1;
                t_cnt <= 1;
            end else if (t_cnt != 0) begin
                t_cnt <= (t_cnt >= rise_dly + busy_len) ? 0 : t_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_length = 8'd0; bus.req0_type = 8'd0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_length = 8'd0; bus.req1_type = 8'd0; bus.req1_data = '0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!bus.busy && t_cnt == 0) break;
        end
        if (k == 3000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_bytes(input string tag, input int base, input int exp_n,
                               input logic [7:0] exp_lb, input logic [7:0] typ,
                               input logic [63:0] data);
        logic [7:0] e;
        int got_n;
        got_n = cap_q.size() - base;
        chk({tag, "_count"}, 64'(got_n), 64'(exp_n));
        for (int k = 0; k < exp_n && k < got_n; k++) begin
            if (k == 0)      e = exp_lb;
            else if (k < 3)  e = 8'h00;
            else if (k == 3) e = typ;
            else             e = data[63 - 8*(k-4) -: 8];
            chk($sformatf("%s_byte%0d", tag, k + 1), 64'(cap_q[base + k]), 64'(e));
        end
    endtask

    task automatic run_pkt(input int id, input bit sel, input logic [7:0] len,
                           input logic [7:0] typ, input logic [63:0] data,
                           input int exp_n, input logic [7:0] exp_lb);
        int base, r0, r1, wb, k;
        bit seen;
        string tag;
        tag = $sformatf("vec%0d", id);
        base = cap_q.size(); r0 = rdy0_cnt; r1 = rdy1_cnt; wb = tx_while_busy;
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_length = len; bus.req1_type = typ; bus.req1_data = data;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_length = len; bus.req0_type = typ; bus.req0_data = data;
        end
        seen = 1'b0;
        for (k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            seen = sel ? bus.req1_ready : bus.req0_ready;
        end
        chk({tag, "_ready_seen"}, 64'(seen), 64'd1);
        // a dropped packet keeps valid through one more edge to probe for a double accept
        if (exp_n == 0) begin
            @(posedge clk); #1;
        end
        clear_reqs();
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_ready_pulses"}, 64'(sel ? rdy1_cnt - r1 : rdy0_cnt - r0), 64'd1);
        chk({tag, "_other_ready"}, 64'(sel ? rdy0_cnt - r0 : rdy1_cnt - r1), 64'd0);
        chk({tag, "_grant"}, 64'(bus.grant), 64'(sel));
        chk({tag, "_tx_while_busy"}, 64'(tx_while_busy - wb), 64'd0);
        check_bytes(tag, base, exp_n, exp_lb, typ, data);
        $display("[TB] %s req%0d L=%0d type=%02h bytes=%0d", tag, sel, len, typ, cap_q.size() - base);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] len;
        logic [7:0] typ;
        logic [63:0] data;
        int         rise;
        int         exp_n;
        logic [7:0] exp_lb;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k, w;
        bit got;
        logic [7:0] lb;
        logic [1:0] exp_order[3];

        vecs[0] = '{1'b0, 8'd8,  8'h00, 64'hDEADBEEF13370D13, 1, 8,  8'h08};
        vecs[1] = '{1'b1, 8'd0,  8'h55, 64'h1111111111111111, 1, 0,  8'h00};
        vecs[2] = '{1'b0, 8'd2,  8'hA5, 64'h2222222222222222, 1, 4,  8'h04};
        vecs[3] = '{1'b1, 8'd20, 8'h3C, 64'h0123456789ABCDEF, 1, 12, 8'h0C};
        vecs[4] = '{1'b0, 8'd5,  8'h77, 64'hAABBCCDDEEFF0011, 3, 5,  8'h05};
        vecs[5] = '{1'b1, 8'd12, 8'h9E, 64'hF0E1D2C3B4A59687, 3, 12, 8'h0C};
        vecs[6] = '{1'b0, 8'd4,  8'h42, 64'h3333333333333333, 1, 4,  8'h04};
        vecs[7] = '{1'b1, 8'd13, 8'h81, 64'h0102030405060708, 1, 12, 8'h0C};
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd0;

        clear_reqs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_transmit", 64'(bus.transmit), 64'd0);
        chk("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            rise_dly = vecs[v].rise;
            run_pkt(v, vecs[v].sel, vecs[v].len, vecs[v].typ, vecs[v].data,
                    vecs[v].exp_n, vecs[v].exp_lb);
        end
        rise_dly = 1;

        // minimum latency: ready one cycle after the sampling edge, transmit one cycle later
        base = cap_q.size();
        bus.req0_valid = 1'b1; bus.req0_length = 8'd4; bus.req0_type = 8'h11; bus.req0_data = '0;
        @(posedge clk); #1;
        chk("lat_ready", 64'(bus.req0_ready), 64'd1);
        chk("lat_no_tx_yet", 64'(bus.transmit), 64'd0);
        chk("lat_busy", 64'(bus.busy), 64'd1);
        clear_reqs();
        @(posedge clk); #1;
        chk("lat_transmit", 64'(bus.transmit), 64'd1);
        chk("lat_first_byte", 64'(bus.tx_byte), 64'h04);
        wait_idle();
        check_bytes("lat", base, 4, 8'h04, 8'h11, 64'd0);
        $display("[TB] latency req0 L=4 bytes=%0d", cap_q.size() - base);

        // contention after reset: req0, req1, req0
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            base = cap_q.size();
            bus.req0_valid = 1'b1; bus.req0_length = 8'd4; bus.req0_type = 8'h10; bus.req0_data = '0;
            bus.req1_valid = 1'b1; bus.req1_length = 8'd4; bus.req1_type = 8'h21; bus.req1_data = '0;
            got = 1'b0; w = 0;
            for (k = 0; k < 50 && !got; k++) begin
                @(posedge clk); #1;
                if (bus.req0_ready || bus.req1_ready) begin
                    got = 1'b1;
                    w = bus.req1_ready ? 1 : 0;
                end
            end
            chk($sformatf("cont%0d_ready_seen", c), 64'(got), 64'd1);
            clear_reqs();
            wait_idle();
            chk($sformatf("cont%0d_winner", c), 64'(w), 64'(exp_order[c]));
            check_bytes($sformatf("cont%0d", c), base, 4, 8'h04,
                        (exp_order[c] == 2'd1) ? 8'h21 : 8'h10, 64'd0);
            $display("[TB] contention %0d winner=req%0d bytes=%0d", c, w, cap_q.size() - base);
        end

        // reset while byte 5 of a 12-byte packet is on the wire
        base = cap_q.size();
        bus.req0_valid = 1'b1; bus.req0_length = 8'd12; bus.req0_type = 8'h66;
        bus.req0_data = 64'hCAFEF00D12345678;
        got = 1'b0;
        for (k = 0; k < 400 && !got; k++) begin
            @(posedge clk); #1;
            if (bus.req0_ready) bus.req0_valid = 1'b0;
            if (bus.transmit && (cap_q.size() - base == 4)) got = 1'b1;
        end
        chk("midrst_reached_byte5", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_transmit", 64'(bus.transmit), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_grant", 64'(bus.grant), 64'd1);
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_bytes_before", 64'(cap_q.size() - base), 64'd4);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lb = 8'd4;
        run_pkt(100, 1'b1, lb, 8'h5A, 64'hFFFFFFFFFFFFFFFF, 4, 8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: PAYLOAD_W, 64, payload field width in bits; max payload bytes PB = PAYLOAD_W/8.
REQ-002 sys_clk  in  1  single clock (UART clock domain); all logic is on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N holds a packet; held with its data until reqN_ready is seen.
REQ-005 reqN_length  in  8  packet length byte L, header included.
REQ-006 reqN_type  in  8  message type byte.
REQ-007 reqN_data  in  PAYLOAD_W  payload, MSB byte sent first.
REQ-008 reqN_ready  out  1  one-cycle accept pulse to requester N.
REQ-009 transmit  out  1  one-cycle pulse to the UART byte transmitter.
REQ-010 tx_byte  out  8  byte to transmit; valid while transmit=1.
REQ-011 is_transmitting  in  1  UART busy flag.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 grant  out  1  index of the requester currently or last served.

Function
REQ-014 Packet length normalisation, applied at accept: L=0 drops the packet; L=1..3 becomes 4; L>4+PB becomes 4+PB. The normalised L is used as the length byte and the byte count.
REQ-015 Wire byte order, index i=1..L: byte 1 = L, bytes 2-3 = 8'h00, byte 4 = type, bytes 5..L = data bytes, MSB first.
REQ-016 FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-017 IDLE, at an edge with any reqN_valid=1:
- latch the winner's length, type and data;
- set i=1 and update grant;
- drive reqN_ready=1 for exactly the following cycle;
- go to SEND, or stay in IDLE if L=0 (packet dropped).
REQ-018 Arbitration:
- one requester valid: it wins;
- both valid: the requester not equal to grant wins (round-robin);
- after reset, req0 wins a tie.
REQ-019 SEND: when is_transmitting=0, register transmit=1 and tx_byte=byte(i), then go to WAIT_ACK; otherwise hold in SEND.
REQ-020 transmit is high for exactly one cycle per byte and is never asserted outside SEND-to-WAIT_ACK transitions.
REQ-021 WAIT_ACK: wait for is_transmitting=1, then go to WAIT_DONE; this prevents a double send before the UART raises busy.
REQ-022 WAIT_DONE: when is_transmitting=0:
- if i==L, go to IDLE;
- else i<=i+1 and go to SEND.
REQ-023 Payload bytes are taken from a shift register loaded at accept, shifted left 8 bits per payload byte sent.
REQ-024 reqN_valid changes while busy=1 are ignored; requests are not queued beyond the valid/ready handshake.
REQ-025 A requester that deasserts valid before ready is not served; no partial accept.
REQ-026 i is 8 bits and never exceeds L; no wrap-around is possible given REQ-014.
REQ-027 Minimum latency: valid sampled at edge k gives ready high in cycle k+1 and the first transmit pulse in cycle k+2 when the UART is idle.

Reset
REQ-028 While rst_n=0, asynchronously and immediately: state=IDLE, transmit=0, tx_byte=0, reqN_ready=0, busy=0, grant=1 (so req0 wins the next tie), i=0, latched packet=0.
REQ-029 Reset mid-packet abandons the packet; the first byte after release is byte 1 of a newly accepted packet.

Verification
REQ-030 Single packet: req0 L=8, type=8'h00, data=64'hDEADBEEF13370D13, UART model with busy 10 cycles -> bytes 08,00,00,00,DE,AD,BE,EF; req0_ready pulses once; busy falls after the 8th busy period.
REQ-031 Contention: req0 and req1 valid in the same cycle, three times, after reset -> service order req0, req1, req0; no interleaving of bytes between packets.
REQ-032 Length edges:
- L=0 -> ready pulse, no transmit;
- L=2 -> 4 bytes with length byte 04;
- L=20 with PAYLOAD_W=64 -> 12 bytes with length byte 0C.
REQ-033 UART handshake: is_transmitting rises 3 cycles after each transmit pulse -> exactly one transmit pulse per byte, none while is_transmitting=1.
REQ-034 Reset mid-operation: rst_n low during byte 5 of a 12-byte packet -> transmit=0 in the same cycle; after release, req1 L=4 sends 04,00,00,type only.
